dlf16_accumulator: RTL

- Streaming accumulator for DLFloat16 values, placed directly downstream of the DLFloat16 multiplier. It sums the multiplier's 16-bit products to form dot products.
- Each input packet is a run of beats ending with in_last. The block adds the beats one at a time through a multi-cycle ALIGN/ADD/NORM datapath.
- At the end of each packet it emits the DLFloat16 sum and the beat count over a valid/ready handshake.

---
 rtl/dlf16_accumulator.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dlf16_accumulator.sv
// dlf16_accumulator: streaming DLFloat16 summer placed behind the DLFloat16 multiplier.
// Each beat passes ALIGN/ADD/NORM (one beat per four cycles); packet sums leave on a valid/ready port.
module dlf16_accumulator #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
   output logic [CNT_W-1:0] out_count
);

   typedef enum logic [2:0] {S_WAIT, S_ALIGN, S_ADD, S_NORM, S_OUT} state_t;

   localparam logic [5:0]       EXP_MAX  = 6'd62;
   localparam logic [8:0]       MANT_MAX = 9'h1FF;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state;
   logic [15:0]      acc;
   logic [15:0]      beat;
   logic             beat_last;
   logic [CNT_W-1:0] count;

   logic             al_sign_a, al_sign_b;
   logic [9:0]       al_sig_a, al_sig_b;
   logic [5:0]       al_exp;

   logic             sum_sign;
   logic [10:0]      sum_mag;
   logic [5:0]       sum_exp;

   // ALIGN: operand A is the accumulator, operand B the latched beat.
   logic [15:0] op_b;
   logic [5:0]  exp_a, exp_b, exp_diff, align_exp;
   logic [9:0]  sig_a, sig_b, align_sig_a, align_sig_b;

   always_comb begin
      op_b        = (beat[14:9] == 6'h3F) ? {beat[15], EXP_MAX, MANT_MAX} : beat;
      exp_a       = acc[14:9];
      exp_b       = op_b[14:9];
      sig_a       = (exp_a != 6'd0) ? {1'b1, acc[8:0]}  : 10'd0;
      sig_b       = (exp_b != 6'd0) ? {1'b1, op_b[8:0]} : 10'd0;
      align_sig_a = sig_a;
      align_sig_b = sig_b;
      exp_diff    = 6'd0;
      align_exp   = exp_a;
      if (exp_a >= exp_b) begin
         exp_diff    = exp_a - exp_b;
         align_exp   = exp_a;
         align_sig_b = (exp_diff >= 6'd11) ? 10'd0 : (sig_b >> exp_diff);
      end else begin
         exp_diff    = exp_b - exp_a;
         align_exp   = exp_b;
         align_sig_a = (exp_diff >= 6'd11) ? 10'd0 : (sig_a >> exp_diff);
      end
   end

   // ADD: sign-magnitude add; a magnitude tie leaves a zero that NORM turns into +0.
   logic [10:0] add_mag;
   logic        add_sign;

   always_comb begin
      add_mag  = 11'd0;
      add_sign = 1'b0;
      if (al_sign_a == al_sign_b) begin
         add_mag  = {1'b0, al_sig_a} + {1'b0, al_sig_b};
         add_sign = al_sign_a;
      end else if (al_sig_a > al_sig_b) begin
         add_mag  = {1'b0, al_sig_a - al_sig_b};
         add_sign = al_sign_a;
      end else if (al_sig_b > al_sig_a) begin
         add_mag  = {1'b0, al_sig_b - al_sig_a};
         add_sign = al_sign_b;
      end
   end

   // NORM: single-cycle priority encode of the leading one, truncating throughout.
   logic [3:0]  lead_shift;
   logic [8:0]  norm_mant;
   logic [6:0]  exp_inc;
   logic [15:0] norm_res;

   always_comb begin
      lead_shift = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (sum_mag[i]) lead_shift = 4'(9 - i);
      end
      norm_mant = 9'(sum_mag[9:0] << lead_shift);
      exp_inc   = {1'b0, sum_exp} + 7'd1;
      norm_res  = 16'h0000;
      if (sum_mag[10]) begin
         if (exp_inc > {1'b0, EXP_MAX}) norm_res = {sum_sign, EXP_MAX, MANT_MAX};
         else                           norm_res = {sum_sign, exp_inc[5:0], sum_mag[9:1]};
      end else if ((sum_mag != 11'd0) && (sum_exp > {2'b00, lead_shift})) begin
         norm_res = {sum_sign, sum_exp - {2'b00, lead_shift}, norm_mant};
      end
   end

   // NOTE: every register here uses non-blocking assignment so all stages update
   // from the same pre-edge values; blocking would let ALIGN see this edge's beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_WAIT;
         acc       <= 16'h0000;
         beat      <= 16'h0000;
         beat_last <= 1'b0;
         count     <= '0;
         al_sign_a <= 1'b0;
         al_sign_b <= 1'b0;
         al_sig_a  <= 10'd0;
         al_sig_b  <= 10'd0;
         al_exp    <= 6'd0;
         sum_sign  <= 1'b0;
         sum_mag   <= 11'd0;
         sum_exp   <= 6'd0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= 16'h0000;
         out_count <= '0;
      end else begin
         case (state)
            S_WAIT: begin
               if (in_valid) begin
                  beat      <= in_data;
                  beat_last <= in_last;
                  if (count != CNT_MAX) count <= count + 1'b1;
                  in_ready  <= 1'b0;
                  state     <= S_ALIGN;
               end
            end
            S_ALIGN: begin
               al_sign_a <= acc[15];
               al_sign_b <= op_b[15];
               al_sig_a  <= align_sig_a;
               al_sig_b  <= align_sig_b;
               al_exp    <= align_exp;
               state     <= S_ADD;
            end
            S_ADD: begin
               sum_sign <= add_sign;
               sum_mag  <= add_mag;
               sum_exp  <= al_exp;
               state    <= S_NORM;
            end
            S_NORM: begin
               acc <= norm_res;
               if (beat_last) begin
                  out_data  <= norm_res;
                  out_count <= count;
                  out_valid <= 1'b1;
                  state     <= S_OUT;
               end else begin
                  in_ready <= 1'b1;
                  state    <= S_WAIT;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  acc       <= 16'h0000;
                  count     <= '0;
                  in_ready  <= 1'b1;
                  state     <= S_WAIT;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= S_WAIT;
            end
         endcase
      end
   end

endmodule
